// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction memory handshake, decoder hookup and execute status.
// The master side is the sequencer; the slave side is memory, decoder and datapath.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    logic [31:0] instruction;
    logic [1:0]  cnt_set;
    logic        stop;
    logic        ins_JAL;
    logic [31:0] IM;

    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        exec_valid;
    logic [1:0]  exec_step;
    logic        halted;
    logic        fault;

    modport master (
        output imem_req, imem_addr, instruction, pc, link_addr,
               exec_valid, exec_step, halted, fault,
        input  imem_rdata, imem_ready, cnt_set, stop, ins_JAL, IM
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc, link_addr,
               exec_valid, exec_step, halted, fault,
        output imem_rdata, imem_ready, cnt_set, stop, ins_JAL, IM
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning PC and IR.
// Latency: fetch cycles (>=1) + 1 decode + (N+1) execute per instruction.
// Backpressure: imem_req/imem_addr held stable until imem_ready; halt is absorbing.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  n_q, n_d;
    logic        jal_q, jal_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic        armed_q, armed_d;

    logic [31:0] jal_offset;
    logic        unused_im_hi;

    // JAL immediate carries imm[20:1]; rebuild the byte offset with sign extension.
    assign jal_offset   = {{11{bus.IM[19]}}, bus.IM[19:0], 1'b0};
    assign unused_im_hi = ^bus.IM[31:20];

    // The request stays low for the first cycle out of reset so a fetch in
    // flight when reset hit is visibly abandoned before restarting at RESET_PC.
    assign bus.imem_req    = (state_q == ST_FETCH) && armed_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = ir_q;
    assign bus.pc          = pc_q;
    assign bus.link_addr   = pc_q + 32'd4;
    assign bus.exec_valid  = (state_q == ST_EXEC);
    assign bus.exec_step   = (state_q == ST_EXEC) ? step_q : 2'd0;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        target_d = target_q;
        step_d   = step_q;
        n_d      = n_q;
        jal_d    = jal_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        armed_d  = 1'b1;

        case (state_q)
            ST_FETCH: begin
                if (armed_q && bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.stop) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    n_d      = bus.cnt_set;
                    jal_d    = bus.ins_JAL;
                    target_d = pc_q + jal_offset;
                    step_d   = 2'd0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (step_q != n_q) begin
                    step_d = step_q + 2'd1;
                end else if (!jal_q) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end else if (target_q[1]) begin
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    pc_d    = target_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            target_q <= 32'd0;
            step_q   <= 2'd0;
            n_q      <= 2'd0;
            jal_q    <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            target_q <= target_d;
            step_q   <= step_d;
            n_q      <= n_d;
            jal_q    <= jal_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            armed_q  <= armed_d;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle front end of the CPU: owns the program counter and instruction register, fetches one instruction at a time from instruction memory, and presents it to the combinational instruction decoder. It samples the decoder's `cnt_set`, `stop`, `ins_JAL` and `IM` results. It then drives the execute-step counter the datapath uses to sequence each instruction, and updates the PC (sequential or JAL target) at the end of execution. It sits directly upstream of the decoder and feeds it through `instruction`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

- `clk`  in  1  single system clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  fetch request, held until accepted.
- `imem_addr`  out  32  fetch address (= `pc` while `imem_req`=1).
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1.
- `imem_ready`  in  1  memory accepts request / returns data this cycle.
- `instruction`  out  32  IR contents, to decoder.
- `cnt_set`  in  2  decoder: last execute step index N for this instruction.
- `stop`  in  1  decoder: unrecognised opcode.
- `ins_JAL`  in  1  decoder: instruction is JAL.
- `IM`  in  32  decoder immediate; for JAL, `IM[19:0]` = imm[20:1], `IM[19]` = sign.
- `pc`  out  32  current PC.
- `link_addr`  out  32  `pc + 4`, combinational, for JAL rd write-back.
- `exec_valid`  out  1  instruction in execute phase.
- `exec_step`  out  2  current execute step, 0..N.
- `halted`  out  1  sequencer stopped, sticky until reset.
- `fault`  out  1  halt caused by a misaligned JAL target, sticky until reset.

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- Reset (`rst_n`=0 at an edge) gives: state FETCH, `pc`=RESET_PC, IR=0, step=0, N=0, `halted`=0, `fault`=0.
- `imem_req`=1 only in FETCH. `exec_valid`=1 only in EXEC. `exec_step`=0 outside EXEC.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, both stable while `imem_ready`=0.
  - On an edge with `imem_ready`=1: IR <= `imem_rdata`, go to DECODE.
- DECODE (exactly 1 cycle), decoder inputs sampled at the end edge:
  - `stop`=1: go to HALT, `halted` <= 1, PC unchanged.
  - Otherwise: N <= `cnt_set`, jal_r <= `ins_JAL`, target_r <= `pc` + {{11{IM[19]}}, IM[19:0], 1'b0} (mod 2^32), step <= 0, go to EXEC.
- EXEC runs steps 0..N, i.e. N+1 cycles. Step increments each edge while step < N. On the edge where step == N:
  - jal_r=0: `pc` <= `pc`+4, go to FETCH.
  - jal_r=1 and target_r[1:0]==0: `pc` <= target_r, go to FETCH.
  - jal_r=1 and target_r[1]==1: `halted` <= 1, `fault` <= 1, `pc` unchanged, go to HALT.
- HALT: absorbing. No request, no execute. Only `rst_n` exits.
- IR, `pc`, N and target_r are stable from DECODE through the last EXEC cycle. `cnt_set`/`stop`/`IM` are ignored outside DECODE.
- Arithmetic: all PC math is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0. Negative JAL offsets are legal.

## Timing
- Reset is synchronous and overrides every state, including a pending fetch: `imem_req` drops in the cycle after the reset edge, then re-asserts with `imem_addr`=RESET_PC once reset is released.
- Fetch with zero wait states: 1 FETCH cycle. Each cycle of `imem_ready`=0 adds one cycle.
- Per-instruction latency: F (fetch cycles, ≥1) + 1 + (N+1). With F=1 and N=0 this is 3 cycles.
- The next `imem_req` rises in the cycle immediately after the last EXEC cycle, with the updated address.
- `halted` and `fault` are registered: high in the first HALT cycle.
- `link_addr` tracks `pc` combinationally. It equals the pre-jump `pc+4` throughout EXEC.

## Test plan
- Reset: RESET_PC=0x100, `rst_n` low 2 cycles then high -> cycle after release `imem_req`=1, `imem_addr`=0x100. `halted`=0, `exec_valid`=0, `instruction`=0.
- Sequential: `imem_ready`=1, `cnt_set`=2, `stop`=0, `ins_JAL`=0 -> `exec_valid` for 3 cycles with `exec_step` 0,1,2. `pc` becomes 0x104 and the next `imem_addr`=0x104, 5 cycles after the first request.
- Wait states: `imem_ready` low 3 cycles -> `imem_req`=1 with `imem_addr` unchanged for 4 cycles. IR is loaded only on the ready edge.
- JAL backward: `pc`=0x200, `ins_JAL`=1, `IM`=0x000F_FFFE, `cnt_set`=1 -> `link_addr`=0x204 during EXEC. Next `imem_addr`=0x1FC.
- Stop: `stop`=1 in DECODE at `pc`=0x108 -> `halted`=1 the next cycle. `imem_req` and `exec_valid` stay 0 for 20+ cycles. `pc`=0x108. Reset restarts the fetch at RESET_PC.
- Misaligned JAL and wrap: `pc`=0x300, `IM`=0x0000_0001 -> `fault`=`halted`=1, `pc`=0x300. Separately, `pc`=0xFFFF_FFFC non-JAL -> next `imem_addr`=0x0000_0000.
